// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared symbols, sender states and lock states for the A/B/C/D lock
package lock_pkg;

    localparam logic [1:0] SYM_A = 2'd0;
    localparam logic [1:0] SYM_B = 2'd1;
    localparam logic [1:0] SYM_C = 2'd2;
    localparam logic [1:0] SYM_D = 2'd3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRESS = 3'd1,
        GAP   = 3'd2,
        WAIT  = 3'd3,
        CLEAR = 3'd4,
        DONE  = 3'd5
    } sender_state_t;

    localparam logic [2:0] LOCK_I = 3'd0;
    localparam logic [2:0] LOCK_A = 3'd1;
    localparam logic [2:0] LOCK_B = 3'd2;
    localparam logic [2:0] LOCK_C = 3'd3;
    localparam logic [2:0] LOCK_D = 3'd4;

endpackage

// File: rtl/lock_sym_onehot.sv
// rtl/lock_sym_onehot.sv - 2-bit symbol to one-hot key vector, bit 0 = A
module lock_sym_onehot
    import lock_pkg::*;
(
    input  logic [1:0] sym,
    input  logic       en,
    output logic [3:0] keys
);

    always_comb begin
        keys = 4'b0000;
        if (en) begin
            case (sym)
                SYM_A:   keys = 4'b0001;
                SYM_B:   keys = 4'b0010;
                SYM_C:   keys = 4'b0100;
                default: keys = 4'b1000;
            endcase
        end
    end

endmodule

// File: rtl/lock_code_sender.sv
// rtl/lock_code_sender.sv - replays a stored code as key pulses and retries until unlocked
module lock_code_sender
    import lock_pkg::*;
#(
    parameter int CODE_LEN       = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int UNLOCK_TIMEOUT = 8,
    parameter int MAX_RETRY      = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [2*CODE_LEN-1:0]          code,
    input  logic                           unlocked,
    output logic                           outA,
    output logic                           outB,
    output logic                           outC,
    output logic                           outD,
    output logic                           busy,
    output logic                           done,
    output logic                           success,
    output logic                           fail,
    output logic [$clog2(MAX_RETRY+1)-1:0] attempts
);

    localparam int SW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int WW = (UNLOCK_TIMEOUT > 1) ? $clog2(UNLOCK_TIMEOUT) : 1;
    localparam int AW = $clog2(MAX_RETRY + 1);

    sender_state_t         state, state_n;
    logic [2*CODE_LEN-1:0] code_q;
    logic [SW-1:0]         sym_idx;
    logic [GW-1:0]         gap_cnt;
    logic [WW-1:0]         wait_cnt;
    logic [1:0]            cur_sym;
    logic                  key_en;
    logic [3:0]            keys;

    wire gap_last  = (gap_cnt == GW'(GAP_CYCLES - 1));
    wire wait_last = (wait_cnt == WW'(UNLOCK_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            code_q   <= '0;
            sym_idx  <= '0;
            gap_cnt  <= '0;
            wait_cnt <= '0;
            attempts <= '0;
            success  <= 1'b0;
            fail     <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (start) begin
                    code_q   <= code;
                    sym_idx  <= '0;
                    attempts <= AW'(1);
                    success  <= 1'b0;
                    fail     <= 1'b0;
                end
                PRESS: gap_cnt <= '0;
                GAP: begin
                    gap_cnt <= gap_cnt + GW'(1);
                    if (state_n == PRESS) sym_idx <= sym_idx + SW'(1);
                    if (state_n == WAIT) wait_cnt <= '0;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + WW'(1);
                    // Verdict is latched on the way into DONE so it is visible alongside done.
                    if (state_n == DONE) begin
                        success <= unlocked;
                        fail    <= ~unlocked;
                    end
                    if (state_n == CLEAR) gap_cnt <= '0;
                end
                CLEAR: begin
                    gap_cnt <= gap_cnt + GW'(1);
                    if (state_n == PRESS) begin
                        sym_idx  <= '0;
                        attempts <= attempts + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (start) state_n = PRESS;
            PRESS: state_n = GAP;
            GAP:   if (gap_last) state_n = (sym_idx == SW'(CODE_LEN - 1)) ? WAIT : PRESS;
            WAIT: begin
                if (unlocked)
                    state_n = DONE;
                else if (wait_last)
                    state_n = (attempts == AW'(MAX_RETRY)) ? DONE : CLEAR;
            end
            CLEAR: if (gap_last) state_n = PRESS;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        key_en = (state == PRESS);
        busy   = (state != IDLE);
        done   = (state == DONE);
    end

    assign cur_sym = code_q[2*int'(sym_idx) +: 2];

    lock_sym_onehot u_onehot (
        .sym  (cur_sym),
        .en   (key_en),
        .keys (keys)
    );

    assign {outD, outC, outB, outA} = keys;

endmodule

// File: tb/tb_lock_code_sender.sv
// tb/tb_lock_code_sender.sv - phase-arithmetic reference model, directed timing pins and random traffic
module tb_lock_code_sender;
    import lock_pkg::*;

    localparam int L = 4, G = 2, T = 8, M = 3;
    localparam int P = L * (1 + G);

    logic       clk = 1'b0;
    logic       rst = 1'b1, start = 1'b0, unl_drv = 1'b0, loop_mode = 1'b0;
    logic [7:0] code = 8'h00;
    logic       outA, outB, outC, outD, busy, done, success, fail;
    logic [1:0] attempts;
    logic [2:0] lock_st = LOCK_I;
    wire        unlocked = loop_mode ? (lock_st == LOCK_D) : unl_drv;
    wire  [3:0] keys = {outD, outC, outB, outA};

    lock_code_sender #(.CODE_LEN(L), .GAP_CYCLES(G), .UNLOCK_TIMEOUT(T), .MAX_RETRY(M)) dut (
        .clk(clk), .rst(rst), .start(start), .code(code), .unlocked(unlocked),
        .outA(outA), .outB(outB), .outC(outC), .outD(outD), .busy(busy), .done(done),
        .success(success), .fail(fail), .attempts(attempts)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // The lock being driven: the right key advances, A always restarts, anything else drops to I.
    always @(posedge clk) begin
        if (rst) lock_st <= LOCK_I;
        else if (keys[0]) lock_st <= LOCK_A;
        else if (keys[1]) lock_st <= (lock_st == LOCK_A) ? LOCK_B : LOCK_I;
        else if (keys[2]) lock_st <= (lock_st == LOCK_B) ? LOCK_C : LOCK_I;
        else if (keys[3]) lock_st <= (lock_st == LOCK_C) ? LOCK_D : LOCK_I;
    end

    // Reference: mode 0 idle, 1 running, 2 done; ph counts cycles since the attempt began.
    int         mode = 0, ph = 0, att = 0;
    logic [7:0] mcode = 8'h00;
    logic       ms = 1'b0, mf = 1'b0;
    logic [3:0] e_keys = 4'b0;

    always @(posedge clk) begin
        if (rst) begin
            mode = 0; att = 0; ms = 1'b0; mf = 1'b0;
        end else begin
            case (mode)
                0: if (start) begin
                    mode = 1; ph = 0; att = 1; mcode = code; ms = 1'b0; mf = 1'b0;
                end
                1: begin
                    if (ph >= P && ph < P + T) begin
                        if (unlocked) begin mode = 2; ms = 1'b1; end
                        else if (ph == P + T - 1 && att == M) begin mode = 2; mf = 1'b1; end
                        else ph++;
                    end else if (ph == P + T + G - 1) begin
                        ph = 0; att++;
                    end else ph++;
                end
                default: mode = 0;
            endcase
        end
        e_keys = 4'b0;
        if (mode == 1 && ph < P && ph % (1 + G) == 0)
            e_keys = 4'b0001 << ((mcode >> (2 * (ph / (1 + G)))) & 8'h3);
    end

    logic chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("keys", keys, e_keys);
            chk("busy", busy, mode != 0);
            chk("done", done, mode == 2);
            chk("success", success, ms);
            chk("fail", fail, mf);
            chk("attempts", attempts, att);
            chk("onehot", $onehot0(keys), 1);
        end
    end

    // Directed recorder: cycle k is the k-th cycle after the edge that samples start.
    logic [3:0] kv [0:127];
    logic       dn [0:127];
    logic       bz [0:127];
    logic [1:0] av [0:127];
    logic       us [0:127];
    int hook_start_at = 0, hook_rst_at = 0;

    task automatic set_unl(input int from, input int to);
        for (int i = 0; i < 128; i++) us[i] = (i >= from && i <= to);
    endtask

    task automatic record(input logic [7:0] c, input int n);
        @(negedge clk);
        code = c; start = 1'b1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            start = 1'b0; rst = 1'b0;
            kv[k] = keys; dn[k] = done; bz[k] = busy; av[k] = attempts;
            unl_drv = us[k];
            if (k == hook_start_at) begin start = 1'b1; code = 8'h00; end
            if (k == hook_rst_at) rst = 1'b1;
        end
        start = 1'b0; rst = 1'b0; unl_drv = 1'b0;
        hook_start_at = 0; hook_rst_at = 0;
    endtask

    task automatic pin_case1(input string tag);
        chk({tag, "_a1"}, kv[1], 4'b0001);
        chk({tag, "_gap2"}, kv[2], 4'b0000);
        chk({tag, "_b4"}, kv[4], 4'b0010);
        chk({tag, "_c7"}, kv[7], 4'b0100);
        chk({tag, "_d10"}, kv[10], 4'b1000);
        chk({tag, "_nodone14"}, dn[14], 1'b0);
        chk({tag, "_done15"}, dn[15], 1'b1);
        chk({tag, "_idle16"}, bz[16], 1'b0);
        chk({tag, "_success"}, success, 1'b1);
        chk({tag, "_att"}, attempts, 2'd1);
    endtask

    int dcnt;

    initial begin
        set_unl(200, 200);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_keys", keys, 4'b0);
        chk("rst_att", attempts, 2'd0);
        chk("rst_flags", {done, success, fail}, 3'b000);
        rst = 1'b0;
        chk_en = 1'b1;

        // case 1: unlock seen in WAIT at cycle 14
        set_unl(14, 14);
        record(8'hE4, 16);
        pin_case1("c1");

        // case 2: never unlocks -> three full attempts then fail
        set_unl(200, 200);
        record(8'hE4, 66);
        dcnt = 0;
        for (int k = 1; k <= 66; k++) if (kv[k][3]) dcnt++;
        chk("c2_dpulses", dcnt, 3);
        chk("c2_done65", dn[65], 1'b1);
        chk("c2_fail", {success, fail}, 2'b01);
        chk("c2_att", attempts, 2'd3);

        // case 3: unlocked high only during key entry must not count
        set_unl(1, 12);
        record(8'hE4, 66);
        chk("c3_nodone14", dn[14], 1'b0);
        chk("c3_a23", kv[23], 4'b0001);
        chk("c3_att23", av[23], 2'd2);
        chk("c3_fail", fail, 1'b1);

        // case 4: start while busy with a new code is ignored
        set_unl(14, 14);
        hook_start_at = 5;
        record(8'hE4, 16);
        pin_case1("c4");

        // case 5: reset mid-GAP, then a clean rerun of case 1
        set_unl(200, 200);
        hook_rst_at = 8;
        record(8'hE4, 10);
        chk("c5_busy9", bz[9], 1'b0);
        chk("c5_keys9", kv[9], 4'b0);
        chk("c5_att", attempts, 2'd0);
        set_unl(14, 14);
        record(8'hE4, 16);
        pin_case1("c5");

        // case 6: closed loop with the lock
        loop_mode = 1'b1;
        @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
        record(8'hE4, 20);
        chk("c6_done14", dn[14], 1'b1);
        chk("c6_success", {success, fail, attempts}, {2'b10, 2'd1});
        @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
        record(8'hE1, 66);
        chk("c6_done65", dn[65], 1'b1);
        chk("c6_fail", {success, fail, attempts}, {2'b01, 2'd3});
        loop_mode = 1'b0;

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            start   = ($urandom % 4) == 0;
            code    = 8'($urandom);
            unl_drv = ($urandom % 12) == 0;
            rst     = ($urandom % 300) == 0;
        end
        @(negedge clk);
        start = 1'b0; rst = 1'b0; unl_drv = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
